apb_register_bank: RTL and testbench
====================================

Name: apb_register_bank

Overview:
- Parametrised APB slave holding NumRegs 32-bit-style registers at consecutive word addresses BaseAddress .. BaseAddress+NumRegs-1.
- Successor to the single write/read register slaves. Each register is individually RW (control), RO (status input) or W1C (sticky event flags).
- Adds configurable wait states, slave error response and per-register write strobes.
- Sits behind the APB multiplexer as one slave occupying a range entry.

Parameters:
- NumRegs, 8, number of registers (1..64).
- BaseAddress, 0, word address of register 0.
- DataWidth, 32, data bus width.
- AddrWidth, 16, address bus width.
- WaitStates, 0, PREADY-low cycles inserted in every access phase (0..15).
- RoMask, '0, NumRegs bits; bit i=1 makes register i read-only (reads ro_value).
- W1cMask, '0, NumRegs bits; bit i=1 makes register i write-1-to-clear sticky. RoMask has priority.
- ResetValue, '0, reset value of every RW register.

Ports:
- PCLK  input  1  APB clock, sole clock.
- PRESET  input  1  asynchronous, active-high reset.
- PADDR  input  AddrWidth  address.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PWRITE  input  1  1=write, 0=read.
- PWDATA  input  DataWidth  write data.
- PRDATA  output  DataWidth  read data; zero except on read completion cycle.
- PREADY  output  1  transfer completion.
- PSLVERROR  output  1  error, valid only with PREADY.
- reg_value  output  NumRegs*DataWidth  current contents, register i at [i*DataWidth +: DataWidth].
- ro_value  input  NumRegs*DataWidth  live inputs for RO registers (other slices ignored).
- status_set  input  NumRegs*DataWidth  per-bit set pulses for W1C registers (other slices ignored).
- wr_pulse  output  NumRegs  one-cycle strobe, register i written successfully.

Behaviour:
- Clock/reset: one clock PCLK; reset PRESET is asynchronous, active-high.
- Reset values: state=IDLE; RW registers=ResetValue; W1C registers=0; PRDATA=0, PREADY=0, PSLVERROR=0, wr_pulse=0. Reset mid-transfer aborts it with no commit.
- Index: idx = PADDR - BaseAddress. The slave is selected only if PSEL and BaseAddress <= PADDR < BaseAddress+NumRegs; otherwise it ignores the bus.
- FSM states IDLE, ACCESS:
  - IDLE: selected & !PENABLE (setup phase) -> ACCESS. Load wait counter with WaitStates, latch idx/PWRITE, capture read data into rd_reg (RO: ro_value slice; otherwise stored register).
  - ACCESS, PENABLE=1, counter>0: decrement, PREADY=0.
  - ACCESS, PENABLE=1, counter=0: completion cycle. PREADY=1 (combinational from state/counter), then -> IDLE.
  - ACCESS, PSEL or PENABLE low before completion (protocol violation): -> IDLE, no commit, no PREADY.
- Latency: completion occurs WaitStates+1 cycles after the setup cycle; back-to-back transfers are allowed (setup may follow immediately).
- Write commit at the completion edge:
  - RW: register <= PWDATA.
  - W1C: register <= (register & ~PWDATA) | status_set slice.
  - RO: no change, PSLVERROR=1 on completion, no wr_pulse.
  - wr_pulse[idx] is asserted on the cycle after a successful commit.
- Read: PRDATA = rd_reg on the completion cycle when PWRITE=0, else 0. PSLVERROR=0 on reads.
- W1C capture: each cycle, register |= status_set slice. A simultaneous set and write-1-clear of the same bit leaves the bit set (set wins).
- reg_value RO slices mirror ro_value combinationally; other slices are the flops.

Decomposition:
- Package apb_bank_pkg holds:
  - state_t enum {IDLE, ACCESS};
  - reg_kind_t enum {KIND_RW, KIND_RO, KIND_W1C};
  - function kind_of(i, RoMask, W1cMask).
- One sub-module, apb_bank_cell: a single register with kind parameter, write/clear/set logic and wr_pulse. Instantiated NumRegs times by generate.
- The top level owns the FSM, wait counter, decode and read mux.

Test Plan:
- Reset, then read all 8 regs (WaitStates=0, ResetValue=32'hA5A5_0000) -> RW regs read 32'hA5A5_0000, PREADY high exactly one cycle after setup, PSLVERROR=0.
- Write 32'hDEAD_BEEF to BaseAddress+2 -> reg_value slice 2 = 32'hDEAD_BEEF, wr_pulse=8'b0000_0100 for one cycle; read back matches.
- WaitStates=3: write reg 1 -> PREADY low 3 access cycles then high 1; value unchanged until the completion edge.
- RoMask bit 5, ro_value slice5=32'h1234_5678: read -> 32'h1234_5678; write 0 -> PSLVERROR=1 with PREADY, no wr_pulse, value unchanged.
- W1cMask bit 3: pulse status_set bit0 and bit4 -> reads 32'h11; write 32'h01 with bit0 set pulsed on the commit cycle -> reads 32'h11; write 32'h10 -> reads 32'h01.
- Assert PRESET during ACCESS of a write 32'hFFFF_FFFF with WaitStates=2 -> register stays ResetValue, PREADY/wr_pulse never assert; the next transfer works normally.

Source files
------------

// File: rtl/apb_register_bank_pkg.sv
// Shared types for the APB register bank: FSM states, register kinds
// and the per-register kind decode used at elaboration time.
package apb_bank_pkg;

    localparam int MaxRegs = 64;
    localparam int CntWidth = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic [1:0] {
        KIND_RW,
        KIND_RO,
        KIND_W1C
    } reg_kind_t;

    // Read-only wins over write-1-to-clear when both mask bits are set.
    function automatic reg_kind_t kind_of(
        input int i,
        input logic [MaxRegs-1:0] ro_mask,
        input logic [MaxRegs-1:0] w1c_mask
    );
        if (ro_mask[i]) return KIND_RO;
        if (w1c_mask[i]) return KIND_W1C;
        return KIND_RW;
    endfunction

endpackage

// File: rtl/apb_register_bank_if.sv
// APB bus bundle between a master (or mux) and the register bank.
interface apb_register_bank_if #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 32
);
    logic [AddrWidth-1:0] PADDR;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [DataWidth-1:0] PWDATA;
    logic [DataWidth-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERROR;

    modport master(
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERROR
    );

    modport slave(
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERROR
    );
endinterface

// File: rtl/apb_register_bank_cell.sv
// One bank register: RW control, RO live input or W1C sticky flags,
// plus a one-cycle strobe after every accepted write.
module apb_bank_cell
    import apb_bank_pkg::*;
#(
    parameter int                   DataWidth  = 32,
    parameter reg_kind_t            Kind       = KIND_RW,
    parameter logic [DataWidth-1:0] ResetValue = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DataWidth-1:0] wdata,
    input  logic [DataWidth-1:0] ro,
    input  logic [DataWidth-1:0] set,
    output logic [DataWidth-1:0] value,
    output logic                 wr_pulse
);
    logic [DataWidth-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= (Kind == KIND_W1C) ? '0 : ResetValue;
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= wr_en && (Kind != KIND_RO);
            unique case (Kind)
                KIND_RW:  if (wr_en) q <= wdata;
                // Set is OR-ed last so a coincident set beats the clear.
                KIND_W1C: q <= (wr_en ? (q & ~wdata) : q) | set;
                default:  q <= q;
            endcase
        end
    end

    assign value = (Kind == KIND_RO) ? ro : q;
endmodule

// File: rtl/apb_register_bank.sv
// APB slave with NumRegs RW/RO/W1C registers, programmable wait
// states and an error response on writes to read-only registers.
module apb_register_bank
    import apb_bank_pkg::*;
#(
    parameter int                   NumRegs     = 8,
    parameter int                   BaseAddress = 0,
    parameter int                   DataWidth   = 32,
    parameter int                   AddrWidth   = 16,
    parameter int                   WaitStates  = 0,
    parameter logic [NumRegs-1:0]   RoMask      = '0,
    parameter logic [NumRegs-1:0]   W1cMask     = '0,
    parameter logic [DataWidth-1:0] ResetValue  = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    apb_register_bank_if.slave           bus,
    output logic [NumRegs*DataWidth-1:0] reg_value,
    input  logic [NumRegs*DataWidth-1:0] ro_value,
    input  logic [NumRegs*DataWidth-1:0] status_set,
    output logic [NumRegs-1:0]           wr_pulse
);
    localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [AddrWidth:0] Lo = (AddrWidth + 1)'(BaseAddress);
    localparam logic [AddrWidth:0] Span = (AddrWidth + 1)'(NumRegs);

    state_t                state;
    logic [CntWidth-1:0]   cnt;
    logic [IdxW-1:0]       idx_q;
    logic                  wr_q;
    logic [DataWidth-1:0]  rd_reg;

    logic [AddrWidth:0]    addr_ext;
    logic [AddrWidth:0]    offset;
    logic [IdxW-1:0]       idx;
    logic                  sel;
    logic                  done;

    // Extra top bit keeps the range compare free of wrap-around.
    assign addr_ext = {1'b0, bus.PADDR};
    assign offset   = addr_ext - Lo;
    assign idx      = offset[IdxW-1:0];
    assign sel      = bus.PSEL && (addr_ext >= Lo) && (offset < Span);

    assign done = (state == ACCESS) && (cnt == '0)
                  && bus.PSEL && bus.PENABLE;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state  <= IDLE;
            cnt    <= '0;
            idx_q  <= '0;
            wr_q   <= 1'b0;
            rd_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel && !bus.PENABLE) begin
                        state  <= ACCESS;
                        cnt    <= CntWidth'(WaitStates);
                        idx_q  <= idx;
                        wr_q   <= bus.PWRITE;
                        rd_reg <= reg_value[idx*DataWidth +: DataWidth];
                    end
                end
                ACCESS: begin
                    if (!(bus.PSEL && bus.PENABLE)) state <= IDLE;
                    else if (cnt != '0) cnt <= cnt - 1'b1;
                    else state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PREADY    = done;
    assign bus.PRDATA    = (done && !wr_q) ? rd_reg : '0;
    assign bus.PSLVERROR = done && wr_q && RoMask[idx_q];

    for (genvar i = 0; i < NumRegs; i++) begin : g_cell
        localparam reg_kind_t Kind =
            kind_of(i, MaxRegs'(RoMask), MaxRegs'(W1cMask));

        apb_bank_cell #(
            .DataWidth (DataWidth),
            .Kind      (Kind),
            .ResetValue(ResetValue)
        ) u_cell (
            .clk     (PCLK),
            .rst     (PRESET),
            .wr_en   (done && wr_q && (idx_q == IdxW'(i))),
            .wdata   (bus.PWDATA),
            .ro      (ro_value[i*DataWidth +: DataWidth]),
            .set     (status_set[i*DataWidth +: DataWidth]),
            .value   (reg_value[i*DataWidth +: DataWidth]),
            .wr_pulse(wr_pulse[i])
        );
    end
endmodule

// File: tb/tb_apb_register_bank.sv
// Directed bench for the APB register bank: three instances that differ
// only in wait states share one bus driver selected by dsel.
module tb_apb_register_bank;
    localparam logic [31:0] Rv = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int           dsel;
    logic [15:0]  paddr;
    logic         psel, penable, pwrite;
    logic [31:0]  pwdata;
    logic [255:0] ro_value, status_set;

    logic [255:0] rv0, rv1, rv2;
    logic [7:0]   wp0, wp1, wp2;

    logic [31:0]  prdata;
    logic         pready, pslverr;
    logic [255:0] regs;
    logic [7:0]   wrp;

    int n_checks = 0;
    int n_fail = 0;

    apb_register_bank_if #(.AddrWidth(16), .DataWidth(32)) b0 ();
    apb_register_bank_if #(.AddrWidth(16), .DataWidth(32)) b1 ();
    apb_register_bank_if #(.AddrWidth(16), .DataWidth(32)) b2 ();

    assign b0.PADDR = paddr;
    assign b1.PADDR = paddr;
    assign b2.PADDR = paddr;
    assign b0.PSEL = psel && (dsel == 0);
    assign b1.PSEL = psel && (dsel == 1);
    assign b2.PSEL = psel && (dsel == 2);
    assign b0.PENABLE = penable;
    assign b1.PENABLE = penable;
    assign b2.PENABLE = penable;
    assign b0.PWRITE = pwrite;
    assign b1.PWRITE = pwrite;
    assign b2.PWRITE = pwrite;
    assign b0.PWDATA = pwdata;
    assign b1.PWDATA = pwdata;
    assign b2.PWDATA = pwdata;

    apb_register_bank #(
        .NumRegs(8), .BaseAddress(16), .DataWidth(32), .AddrWidth(16),
        .WaitStates(0), .RoMask(8'h20), .W1cMask(8'h08), .ResetValue(Rv)
    ) dut0 (
        .PCLK(clk), .PRESET(rst), .bus(b0.slave), .reg_value(rv0),
        .ro_value(ro_value), .status_set(status_set), .wr_pulse(wp0)
    );

    apb_register_bank #(
        .NumRegs(8), .BaseAddress(16), .DataWidth(32), .AddrWidth(16),
        .WaitStates(3), .RoMask(8'h20), .W1cMask(8'h08), .ResetValue(Rv)
    ) dut1 (
        .PCLK(clk), .PRESET(rst), .bus(b1.slave), .reg_value(rv1),
        .ro_value(ro_value), .status_set(status_set), .wr_pulse(wp1)
    );

    apb_register_bank #(
        .NumRegs(8), .BaseAddress(16), .DataWidth(32), .AddrWidth(16),
        .WaitStates(2), .RoMask(8'h20), .W1cMask(8'h08), .ResetValue(Rv)
    ) dut2 (
        .PCLK(clk), .PRESET(rst), .bus(b2.slave), .reg_value(rv2),
        .ro_value(ro_value), .status_set(status_set), .wr_pulse(wp2)
    );

    always_comb begin
        prdata  = b0.PRDATA;
        pready  = b0.PREADY;
        pslverr = b0.PSLVERROR;
        regs    = rv0;
        wrp     = wp0;
        if (dsel == 1) begin
            prdata  = b1.PRDATA;
            pready  = b1.PREADY;
            pslverr = b1.PSLVERROR;
            regs    = rv1;
            wrp     = wp1;
        end else if (dsel == 2) begin
            prdata  = b2.PRDATA;
            pready  = b2.PREADY;
            pslverr = b2.PSLVERROR;
            regs    = rv2;
            wrp     = wp2;
        end
    end

    logic watch = 1'b0;
    int   glitch = 0;
    always @(negedge clk)
        if (watch && (b2.PREADY || wp2 != 8'h00)) glitch++;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // lat = cycles from setup to PREADY, -1 if no response within budget;
    // pulse is driven on status_set only during the completion cycle.
    task automatic xfer(input int d, input logic [15:0] a, input logic w,
                        input logic [31:0] wd, input logic [255:0] pulse,
                        output logic [31:0] rd, output logic er,
                        output int lat, output logic [255:0] pre);
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        pre = '0;
        @(posedge clk); #1;
        dsel = d; paddr = a; pwrite = w; pwdata = wd;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pready) begin
                lat = k + 1;
                rd  = prdata;
                er  = pslverr;
                pre = regs;
                status_set = status_set | pulse;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        status_set = status_set & ~pulse;
    endtask

    logic [31:0]  rd;
    logic         er;
    int           lat;
    logic [255:0] pre;
    logic [31:0]  exp_rd;

    initial begin
        rst = 1'b1;
        dsel = 0; paddr = '0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0;
        ro_value = '0;
        ro_value[160 +: 32] = 32'h1234_5678;
        status_set = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 256'(pready), 256'(1'b0));
        check("rst_prdata", 256'(prdata), 256'(32'h0));
        check("rst_pslverr", 256'(pslverr), 256'(1'b0));
        check("rst_wr_pulse", 256'(wrp), 256'(8'h00));
        check("rst_rw_val", 256'(regs[0 +: 32]), 256'(Rv));
        check("rst_w1c_val", 256'(regs[96 +: 32]), 256'(32'h0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            exp_rd = (i == 3) ? 32'h0 : (i == 5) ? 32'h1234_5678 : Rv;
            xfer(0, 16'(16 + i), 1'b0, 32'h0, '0, rd, er, lat, pre);
            check($sformatf("rd_all_%0d", i), 256'(rd), 256'(exp_rd));
            check($sformatf("rd_lat_%0d", i), 256'(32'(lat)), 256'(32'd1));
            check($sformatf("rd_err_%0d", i), 256'(er), 256'(1'b0));
        end

        xfer(0, 16'h12, 1'b1, 32'hDEAD_BEEF, '0, rd, er, lat, pre);
        check("wr2_err", 256'(er), 256'(1'b0));
        check("wr2_prdata_zero", 256'(rd), 256'(32'h0));
        @(negedge clk);
        check("wr2_pulse", 256'(wrp), 256'(8'h04));
        check("wr2_val", 256'(regs[64 +: 32]), 256'(32'hDEAD_BEEF));
        @(negedge clk);
        check("wr2_pulse_off", 256'(wrp), 256'(8'h00));
        xfer(0, 16'h12, 1'b0, 32'h0, '0, rd, er, lat, pre);
        check("rd2_back", 256'(rd), 256'(32'hDEAD_BEEF));

        xfer(0, 16'h18, 1'b1, 32'h0BAD_0BAD, '0, rd, er, lat, pre);
        check("oor_hi_noresp", 256'(32'(lat)), 256'(-32'sd1));
        check("oor_hi_reg0", 256'(regs[0 +: 32]), 256'(Rv));
        xfer(0, 16'h0F, 1'b0, 32'h0, '0, rd, er, lat, pre);
        check("oor_lo_noresp", 256'(32'(lat)), 256'(-32'sd1));

        xfer(1, 16'h11, 1'b1, 32'h0000_CAFE, '0, rd, er, lat, pre);
        check("ws3_lat", 256'(32'(lat)), 256'(32'd4));
        check("ws3_pre_commit", 256'(pre[32 +: 32]), 256'(Rv));
        @(negedge clk);
        check("ws3_val", 256'(regs[32 +: 32]), 256'(32'h0000_CAFE));
        check("ws3_pulse", 256'(wrp), 256'(8'h02));

        xfer(0, 16'h15, 1'b1, 32'h0, '0, rd, er, lat, pre);
        check("ro_wr_err", 256'(er), 256'(1'b1));
        check("ro_wr_lat", 256'(32'(lat)), 256'(32'd1));
        @(negedge clk);
        check("ro_wr_no_pulse", 256'(wrp), 256'(8'h00));
        check("ro_val", 256'(regs[160 +: 32]), 256'(32'h1234_5678));
        xfer(0, 16'h15, 1'b0, 32'h0, '0, rd, er, lat, pre);
        check("ro_rd", 256'(rd), 256'(32'h1234_5678));
        check("ro_rd_err", 256'(er), 256'(1'b0));

        @(posedge clk); #1;
        status_set[96 +: 32] = 32'h11;
        @(posedge clk); #1;
        status_set[96 +: 32] = 32'h0;
        xfer(0, 16'h13, 1'b0, 32'h0, '0, rd, er, lat, pre);
        check("w1c_set", 256'(rd), 256'(32'h11));
        xfer(0, 16'h13, 1'b1, 32'h01, 256'h1 << 96, rd, er, lat, pre);
        @(negedge clk);
        check("w1c_pulse", 256'(wrp), 256'(8'h08));
        xfer(0, 16'h13, 1'b0, 32'h0, '0, rd, er, lat, pre);
        check("w1c_set_wins", 256'(rd), 256'(32'h11));
        xfer(0, 16'h13, 1'b1, 32'h10, '0, rd, er, lat, pre);
        xfer(0, 16'h13, 1'b0, 32'h0, '0, rd, er, lat, pre);
        check("w1c_clear", 256'(rd), 256'(32'h01));

        @(posedge clk); #1;
        dsel = 2; paddr = 16'h14; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
        psel = 1'b1; penable = 1'b0; watch = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 watch = 1'b0;
        check("rstmid_no_resp", 256'(32'(glitch)), 256'(32'd0));
        check("rstmid_val", 256'(regs[128 +: 32]), 256'(Rv));
        xfer(2, 16'h14, 1'b1, 32'h0000_0055, '0, rd, er, lat, pre);
        check("rstmid_next_lat", 256'(32'(lat)), 256'(32'd3));
        @(negedge clk);
        check("rstmid_next_val", 256'(regs[128 +: 32]), 256'(32'h55));
        check("rstmid_next_pulse", 256'(wrp), 256'(8'h10));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
